// File: rtl/gpio_defaults_loader.sv
// gpio_defaults_loader
//
// Holds one configuration word per GPIO channel. The words come up from the
// mask-programmed defaults in GPIO_CONFIG_INIT. Management firmware can
// overwrite single words or restore all of them. On request, or once
// automatically after reset, the block shifts the whole set serially into
// the chain of GPIO control blocks.
//
// Ports
//   clock         block clock; all state changes on the rising edge
//   resetn        synchronous, active-low reset
//   wr_en         write strobe for one configuration word (IDLE only)
//   wr_idx        channel index to write; indices >= NUM_GPIO are dropped
//   wr_data       new configuration word
//   restore       reload every word from GPIO_CONFIG_INIT (IDLE only);
//                 wins over a wr_en in the same cycle
//   start         request a serial transfer
//   gpio_cfg      current words, packed like GPIO_CONFIG_INIT
//   serial_clock  chain shift clock
//   serial_load   chain latch strobe
//   serial_data   chain data; channel NUM_GPIO-1 first, each word MSB first
//   busy          transfer in progress
//   done          one-cycle pulse when a transfer completes
//
// Handshake: start is a request with no ready signal. It is taken only on a
// cycle where the FSM is in IDLE, which includes the cycle that shows done.
// A start seen while busy=1 is dropped and not queued. busy stays high from
// the cycle after the accepted start through the serial_load cycle. done then
// pulses for exactly one cycle as busy falls.
//
// Transfer timing, with start sampled at edge T and N = NUM_GPIO*CFG_WIDTH:
// bit k is driven at T+1+2k with serial_clock low. It is held at T+2+2k with
// serial_clock high. serial_load is high at T+2N+1, and done is high at T+2N+2.

module gpio_defaults_loader #(
  parameter int unsigned NUM_GPIO  = 19,
  parameter int unsigned CFG_WIDTH = 13,
  parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT =
    {NUM_GPIO{CFG_WIDTH'(13'h0402)}},
  parameter bit AUTO_LOAD = 1'b1,
  localparam int unsigned IDX_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [CFG_WIDTH-1:0]          wr_data,
  input  logic                          restore,
  input  logic                          start,
  output logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_cfg,
  output logic                          serial_clock,
  output logic                          serial_load,
  output logic                          serial_data,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned N_BITS = NUM_GPIO * CFG_WIDTH;
  localparam int unsigned CNT_W  = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LOAD     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   cfg_q, cfg_d;
  logic [N_BITS-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sclk_q, sclk_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  // Set by reset. It makes the first IDLE cycle after release behave as if
  // start were asserted, which gives the automatic transfer.
  logic                auto_q, auto_d;

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cfg_q   <= GPIO_CONFIG_INIT;
      sr_q    <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= AUTO_LOAD;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      auto_q  <= auto_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    load_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    auto_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Word updates are accepted only here, so the chain image can never
        // change under a running transfer.
        if (restore) begin
          cfg_d = GPIO_CONFIG_INIT;
        end else if (wr_en) begin
          // Only a matching in-range index writes, so out-of-range
          // indices fall through with no effect.
          for (int i = 0; i < int'(NUM_GPIO); i++) begin
            if (wr_idx == IDX_W'(i)) begin
              cfg_d[i*CFG_WIDTH +: CFG_WIDTH] = wr_data;
            end
          end
        end
        if (start || auto_q) begin
          // The snapshot takes cfg_q, the value before any write in this
          // same cycle. A write that arrives with start is shifted out
          // only by the next transfer.
          state_d = ST_SHIFT_LO;
          sr_d    = cfg_q;
          cnt_d   = '0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SHIFT_LO: begin
        state_d = ST_SHIFT_HI;
        sclk_d  = 1'b1;
      end

      ST_SHIFT_HI: begin
        sclk_d = 1'b0;
        // Zeros are shifted in, so serial_data (the top bit of sr_q) is
        // already 0 by the time the load strobe is shown.
        sr_d   = sr_q << 1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_LOAD;
          load_d  = 1'b1;
        end else begin
          state_d = ST_SHIFT_LO;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_LOAD: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gpio_cfg     = cfg_q;
  assign serial_clock = sclk_q;
  assign serial_load  = load_q;
  assign serial_data  = sr_q[N_BITS-1];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
